// File: rtl/revo_word_scheduler.sv
// -----------------------------------------------------------------------------
// revo_word_scheduler
//
// Builds the 8-bit revolution-marker word stream for an 8:1 output serializer.
// It runs entirely in the serializer word-clock domain.
//
// A word counter walks one accelerator revolution of REVO_WORDS words. A marker
// of MARKER_BITS bits is placed at a bit-granular phase. When the marker starts
// late in a word, it spills into the following word through a tail register.
// This includes the wrap from the last word back to word 0.
//
// Phase updates arrive through a valid/ready handshake and are held as pending.
// While the counter is running, a pending phase is applied only when the word
// index wraps to 0, so the marker never glitches mid-revolution.
//
// Parameters:
//   REVO_WORDS    words per revolution (index range 0..REVO_WORDS-1)
//   MARKER_BITS   marker length in bits (1..8)
//   DEFAULT_PHASE marker start bit position after reset
//   PHASE_WIDTH   width of phase values (2^PHASE_WIDTH >= 8*REVO_WORDS)
//   SYNC_REQUIRED 1: ARMED waits for sync_in; 0: ARMED starts immediately
//
// Ports:
//   clock            word clock
//   reset_n          synchronous active-low reset
//   run              level request to start / keep running
//   sync_in          one-cycle pulse that aligns word 0 while ARMED
//   cfg_valid        phase update request
//   cfg_phase        requested marker start bit position
//   revolution_limit (only with REVO_SCHEDULER_LIMIT_EN) automatic stop after
//                    this many revolutions; 0 = unlimited
//   cfg_ready        a new phase can be accepted
//   revo_word        word to serializer; bit 7 leaves first
//   revo_flag        high on the word holding the marker's first bit
//   word_index       index of the word currently on revo_word
//   revolution_count completed revolutions since leaving IDLE
//   active_phase     phase currently in use
//   state            00 IDLE, 01 ARMED, 10 RUNNING, 11 STOPPING
//
// Optional feature macro: REVO_SCHEDULER_LIMIT_EN (adds revolution_limit).
// -----------------------------------------------------------------------------
module revo_word_scheduler #(
  parameter int REVO_WORDS    = 1280,
  parameter int MARKER_BITS   = 8,
  parameter int DEFAULT_PHASE = 0,
  parameter int PHASE_WIDTH   = 14,
  parameter int SYNC_REQUIRED = 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   run,
  input  logic                   sync_in,
  input  logic                   cfg_valid,
  input  logic [PHASE_WIDTH-1:0] cfg_phase,
`ifdef REVO_SCHEDULER_LIMIT_EN
  input  logic [15:0]            revolution_limit,
`endif
  output logic                   cfg_ready,
  output logic [7:0]             revo_word,
  output logic                   revo_flag,
  output logic [10:0]            word_index,
  output logic [15:0]            revolution_count,
  output logic [PHASE_WIDTH-1:0] active_phase,
  output logic [1:0]             state
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_ARMED    = 2'b01,
    ST_RUNNING  = 2'b10,
    ST_STOPPING = 2'b11
  } state_e;

  localparam int unsigned TOTAL_BITS = 8 * REVO_WORDS;
  localparam logic [10:0] LAST_IDX   = 11'(REVO_WORDS - 1);
  // Marker as a contiguous run of ones, LSB = first bit out.
  localparam logic [15:0] MARK_RUN   = 16'((32'd1 << MARKER_BITS) - 32'd1);

  // Reduce a requested phase into the revolution's bit range.
  function automatic logic [PHASE_WIDTH-1:0] wrap_phase(input logic [PHASE_WIDTH-1:0] p);
    return PHASE_WIDTH'(32'(p) % TOTAL_BITS);
  endfunction

  // Convert "bit b leaves b-th" ordering into the serializer's MSB-first word.
  function automatic logic [7:0] wire_order(input logic [7:0] b);
    return {<<{b}};
  endfunction

  state_e                 state_q, state_d;
  logic [10:0]            idx_q, idx_d;
  logic [7:0]             word_q, word_d;
  logic                   flag_q, flag_d;
  logic [7:0]             tail_q, tail_d;
  logic [15:0]            rev_cnt_q, rev_cnt_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic [PHASE_WIDTH-1:0] pend_q, pend_d;
  logic                   pend_vld_q, pend_vld_d;
  logic                   cfg_ready_q, cfg_ready_d;

  logic                   emit;
  logic                   wrap;
  logic                   at_last;
  logic                   apply;
  logic                   xfer;
  logic                   start_hit;
  logic [15:0]            run_b;
  logic                   limit_hit;

`ifdef REVO_SCHEDULER_LIMIT_EN
  // The revolution now in progress is the last one allowed.
  assign limit_hit = (revolution_limit != 16'd0) &&
                     (rev_cnt_q == revolution_limit - 16'd1);
`else
  assign limit_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rev_cnt_d   = rev_cnt_q;
    emit        = 1'b0;
    wrap        = 1'b0;
    at_last     = (idx_q == LAST_IDX);
    apply       = 1'b0;
    xfer        = 1'b0;
    phase_d     = phase_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    cfg_ready_d = cfg_ready_q;
    start_hit   = 1'b0;
    run_b       = 16'h0000;
    word_d      = 8'h00;
    tail_d      = 8'h00;
    flag_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        idx_d = 11'd0;
        if (run) begin
          state_d   = ST_ARMED;
          rev_cnt_d = 16'd0;
        end
      end
      ST_ARMED: begin
        idx_d = 11'd0;
        // Dropping run wins over a simultaneous sync pulse.
        if (!run) begin
          state_d = ST_IDLE;
        end else if ((SYNC_REQUIRED == 0) || sync_in) begin
          state_d = ST_RUNNING;
          emit    = 1'b1;
        end
      end
      ST_RUNNING, ST_STOPPING: begin
        wrap  = at_last;
        idx_d = at_last ? 11'd0 : idx_q + 11'd1;
        if (at_last) rev_cnt_d = rev_cnt_q + 16'd1;
        emit = 1'b1;
        if (state_q == ST_RUNNING) begin
          if (!run || limit_hit) state_d = ST_STOPPING;
        end else if (run && !limit_hit) begin
          state_d = ST_RUNNING;
        end else if (at_last) begin
          // Revolution finished: park at word 0 and emit only a pending tail.
          state_d = ST_IDLE;
          emit    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A pending phase takes effect at once when stopped, else only at the wrap.
    apply   = pend_vld_q && ((state_q == ST_IDLE) || (state_q == ST_ARMED) || wrap);
    xfer    = cfg_valid && cfg_ready_q;
    phase_d = apply ? pend_q : phase_q;
    if (xfer) pend_d = wrap_phase(cfg_phase);
    pend_vld_d  = xfer || (pend_vld_q && !apply);
    // Ready stays low through the application cycle and returns one cycle later.
    cfg_ready_d = !pend_vld_d && !apply;

    // The word now leaving uses the phase that is in force for it, so a phase
    // applied at the wrap already governs word 0 of the new revolution.
    start_hit = emit && (32'(idx_d) == 32'(phase_d >> 3));
    run_b     = MARK_RUN << phase_d[2:0];
    word_d    = tail_q | (start_hit ? wire_order(run_b[7:0]) : 8'h00);
    tail_d    = start_hit ? wire_order(run_b[15:8]) : 8'h00;
    flag_d    = start_hit;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= 11'd0;
      word_q      <= 8'h00;
      flag_q      <= 1'b0;
      tail_q      <= 8'h00;
      rev_cnt_q   <= 16'd0;
      phase_q     <= PHASE_WIDTH'(DEFAULT_PHASE);
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      flag_q      <= flag_d;
      tail_q      <= tail_d;
      rev_cnt_q   <= rev_cnt_d;
      phase_q     <= phase_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign cfg_ready        = cfg_ready_q;
  assign revo_word        = word_q;
  assign revo_flag        = flag_q;
  assign word_index       = idx_q;
  assign revolution_count = rev_cnt_q;
  assign active_phase     = phase_q;
  assign state            = state_q;

endmodule

// File: tb/tb_revo_word_scheduler.sv
module tb_revo_word_scheduler;

  localparam int RW = 16;
  localparam int PW = 14;

  logic          clock     = 1'b0;
  logic          reset_n   = 1'b0;
  logic          run       = 1'b0;
  logic          sync_in   = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [PW-1:0] cfg_phase = '0;
`ifdef REVO_SCHEDULER_LIMIT_EN
  logic [15:0]   revolution_limit = 16'd0;
`endif
  logic          cfg_ready;
  logic [7:0]    revo_word;
  logic          revo_flag;
  logic [10:0]   word_index;
  logic [15:0]   revolution_count;
  logic [PW-1:0] active_phase;
  logic [1:0]    state;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  revo_word_scheduler #(
    .REVO_WORDS   (RW),
    .MARKER_BITS  (8),
    .DEFAULT_PHASE(0),
    .PHASE_WIDTH  (PW),
    .SYNC_REQUIRED(1)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .run             (run),
    .sync_in         (sync_in),
    .cfg_valid       (cfg_valid),
    .cfg_phase       (cfg_phase),
`ifdef REVO_SCHEDULER_LIMIT_EN
    .revolution_limit(revolution_limit),
`endif
    .cfg_ready       (cfg_ready),
    .revo_word       (revo_word),
    .revo_flag       (revo_flag),
    .word_index      (word_index),
    .revolution_count(revolution_count),
    .active_phase    (active_phase),
    .state           (state)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input int idx, input logic [7:0] w, input logic f);
    chk({tag, "_idx"}, 32'(word_index), 32'(idx));
    chk({tag, "_word"}, 32'(revo_word), 32'(w));
    chk({tag, "_flag"}, 32'(revo_flag), 32'(f));
  endtask

  initial begin
    int flags;

    // Reset state
    step();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_idx", 32'(word_index), 32'd0);
    chk("rst_word", 32'(revo_word), 32'd0);
    chk("rst_flag", 32'(revo_flag), 32'd0);
    chk("rst_cnt", 32'(revolution_count), 32'd0);
    chk("rst_phase", 32'(active_phase), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);

    // Start: IDLE -> ARMED, wait for sync
    reset_n = 1'b1; run = 1'b1;
    step();
    chk("armed", 32'(state), 32'd1);
    step();
    chk("armed_wait", 32'(state), 32'd1);
    chk("armed_word", 32'(revo_word), 32'd0);
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    chk("run_state", 32'(state), 32'd2);
    chk_word("p0_w0", 0, 8'hFF, 1'b1);
    for (int i = 1; i < RW; i++) begin
      step();
      chk_word("p0_wn", i, 8'h00, 1'b0);
    end
    step();
    chk_word("p0_wrap", 0, 8'hFF, 1'b1);
    chk("cnt1", 32'(revolution_count), 32'd1);

    // Phase 40 accepted at word 5; old marker holds until the wrap
    repeat (5) step();
    chk("idx5", 32'(word_index), 32'd5);
    cfg_valid = 1'b1; cfg_phase = 14'd40;
    step();
    cfg_valid = 1'b0;
    chk("p40_ready_lo", 32'(cfg_ready), 32'd0);
    chk("p40_not_yet", 32'(active_phase), 32'd0);
    repeat (9) step();
    chk("idx15", 32'(word_index), 32'd15);
    step();
    chk("p40_applied", 32'(active_phase), 32'd40);
    chk_word("p40_w0", 0, 8'h00, 1'b0);
    chk("p40_ready_still_lo", 32'(cfg_ready), 32'd0);
    step();
    chk("p40_ready_hi", 32'(cfg_ready), 32'd1);
    repeat (4) step();
    chk_word("p40_w5", 5, 8'hFF, 1'b1);

    // Phase 13: marker straddles words 1 and 2
    cfg_valid = 1'b1; cfg_phase = 14'd13;
    step();
    cfg_valid = 1'b0;
    repeat (9) step();
    step();
    chk("p13_applied", 32'(active_phase), 32'd13);
    chk_word("p13_w0", 0, 8'h00, 1'b0);
    step();
    chk_word("p13_w1", 1, 8'h07, 1'b1);
    step();
    chk_word("p13_w2", 2, 8'hF8, 1'b0);
    step();
    chk_word("p13_w3", 3, 8'h00, 1'b0);

    // Phase 200 is out of range: reduced to 72 (word 9)
    cfg_valid = 1'b1; cfg_phase = 14'd200;
    step();
    cfg_valid = 1'b0;
    repeat (11) step();
    step();
    chk("p200_mod", 32'(active_phase), 32'd72);
    repeat (9) step();
    chk_word("p72_w9", 9, 8'hFF, 1'b1);

    // Phase 127 (last bit): tail crosses the wrap; stop during word 10
    cfg_valid = 1'b1; cfg_phase = 14'd127;
    step();
    cfg_valid = 1'b0;
    repeat (5) step();
    chk_word("p72_w15", 15, 8'h00, 1'b0);
    step();
    chk("p127_applied", 32'(active_phase), 32'd127);
    chk_word("p127_w0_first", 0, 8'h00, 1'b0);
    repeat (10) step();
    run = 1'b0;
    step();
    chk("stopping", 32'(state), 32'd3);
    chk("stop_idx", 32'(word_index), 32'd11);
    repeat (4) step();
    chk_word("p127_w15", 15, 8'h01, 1'b1);
    chk("stop_last_state", 32'(state), 32'd3);
    step();
    chk("stop_idle", 32'(state), 32'd0);
    chk_word("tail_after_stop", 0, 8'hFE, 1'b0);
    chk("cnt6", 32'(revolution_count), 32'd6);
    step();
    chk_word("idle_zero", 0, 8'h00, 1'b0);

    // ARMED: run=0 has priority over sync_in
    run = 1'b1;
    step();
    chk("rearm", 32'(state), 32'd1);
    chk("rearm_cnt_clr", 32'(revolution_count), 32'd0);
    run = 1'b0; sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    chk("armed_run0_prio", 32'(state), 32'd0);

    // sync_in ignored while RUNNING, then reset at word 7
    run = 1'b1;
    step();
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    chk_word("p127_restart_w0", 0, 8'h00, 1'b0);
    repeat (3) step();
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    chk("sync_ignored_idx", 32'(word_index), 32'd4);
    chk("sync_ignored_state", 32'(state), 32'd2);
    repeat (3) step();
    chk("pre_rst_idx", 32'(word_index), 32'd7);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("mrst_state", 32'(state), 32'd0);
    chk_word("mrst", 0, 8'h00, 1'b0);
    chk("mrst_phase", 32'(active_phase), 32'd0);
    chk("mrst_ready", 32'(cfg_ready), 32'd1);

    // STOPPING -> RUNNING when run returns
    step();
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    chk_word("rst_p0_w0", 0, 8'hFF, 1'b1);
    run = 1'b0;
    step();
    chk("resume_stop", 32'(state), 32'd3);
    run = 1'b1;
    step();
    chk("resume_run", 32'(state), 32'd2);
    chk("resume_idx", 32'(word_index), 32'd2);

`ifdef REVO_SCHEDULER_LIMIT_EN
    // Limit 3: exactly three markers, IDLE after the third revolution
    revolution_limit = 16'd3;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    flags = int'(revo_flag);
    for (int k = 1; k <= 64; k++) begin
      step();
      flags += int'(revo_flag);
      if (k == 48) chk("lim_idle", 32'(state), 32'd0);
    end
    chk("lim_markers", 32'(flags), 32'd3);
    chk("lim_armed", 32'(state), 32'd1);

    // Limit 0: unlimited
    revolution_limit = 16'd0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    flags = int'(revo_flag);
    for (int k = 1; k <= 64; k++) begin
      step();
      flags += int'(revo_flag);
    end
    chk("nolim_markers", 32'(flags), 32'd5);
    chk("nolim_running", 32'(state), 32'd2);
`else
    flags = 0;
    chk("flags_unused", 32'(flags), 32'(revo_flag & 1'b0));
`endif

    if (n_fail > 0) $display("%0d checks did not match", n_fail);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
